// File: rtl/stage_memory.sv
// Memory pipeline stage: passes execute results through, or runs a lane-serial vector load/store
// over a single-lane req/ack bus. Optional per-lane ack timeout under STAGE_MEMORY_TIMEOUT_EN.
module stage_memory #(
   parameter int unsigned registerSize  = 8,
   parameter int unsigned vectorSize    = 4,
   parameter int unsigned addrSize      = 16,
   parameter int unsigned timeoutCycles = 15
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 valid_in,
   input  logic [1:0]                           memOp,
   input  logic [addrSize-1:0]                  address,
   input  logic [vectorSize*registerSize-1:0]   vect_in,
   output logic                                 stall,
   output logic [vectorSize*registerSize-1:0]   vect_out,
   output logic                                 valid_out,
   output logic                                 mem_req,
   output logic                                 mem_we,
   output logic [addrSize-1:0]                  mem_addr,
   output logic [registerSize-1:0]              mem_wdata,
   input  logic [registerSize-1:0]              mem_rdata,
   input  logic                                 mem_ack,
   output logic                                 mem_error
);

   localparam int unsigned VEC_W  = vectorSize * registerSize;
   localparam int unsigned LANE_W = (vectorSize > 1) ? $clog2(vectorSize) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(vectorSize - 1);
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   typedef enum logic {IDLE, XFER} state_e;

   state_e              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [addrSize-1:0] base_q, base_d;
   logic [VEC_W-1:0]    store_q, store_d;
   logic                is_load_q, is_load_d;
   logic [VEC_W-1:0]    buf_q, buf_d;
   logic [VEC_W-1:0]    vect_out_q, vect_out_d;
   logic                valid_q, valid_d;

`ifdef STAGE_MEMORY_TIMEOUT_EN
   localparam int unsigned TMO_W = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
   logic [TMO_W-1:0]    wait_q, wait_d;
   logic                err_q, err_d;
`endif

   // Bus outputs derive only from registers, so an async reset drops them at once
   assign stall     = (state_q == XFER);
   assign mem_req   = (state_q == XFER);
   assign mem_we    = (state_q == XFER) & ~is_load_q;
   assign mem_addr  = base_q + addrSize'(lane_q);
   assign mem_wdata = store_q[lane_q*registerSize +: registerSize];
   assign vect_out  = vect_out_q;
   assign valid_out = valid_q;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         lane_q     <= '0;
         base_q     <= '0;
         store_q    <= '0;
         is_load_q  <= 1'b0;
         buf_q      <= '0;
         vect_out_q <= '0;
         valid_q    <= 1'b0;
`ifdef STAGE_MEMORY_TIMEOUT_EN
         wait_q     <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         base_q     <= base_d;
         store_q    <= store_d;
         is_load_q  <= is_load_d;
         buf_q      <= buf_d;
         vect_out_q <= vect_out_d;
         valid_q    <= valid_d;
`ifdef STAGE_MEMORY_TIMEOUT_EN
         wait_q     <= wait_d;
         err_q      <= err_d;
`endif
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      base_d     = base_q;
      store_d    = store_q;
      is_load_d  = is_load_q;
      buf_d      = buf_q;
      vect_out_d = vect_out_q;
      valid_d    = 1'b0;
`ifdef STAGE_MEMORY_TIMEOUT_EN
      wait_d     = wait_q;
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               if (memOp == OP_LOAD || memOp == OP_STORE) begin
                  base_d    = address;
                  store_d   = vect_in;
                  is_load_d = (memOp == OP_LOAD);
                  lane_d    = '0;
                  state_d   = XFER;
`ifdef STAGE_MEMORY_TIMEOUT_EN
                  wait_d    = '0;
`endif
               end else begin
                  vect_out_d = vect_in;
                  valid_d    = 1'b1;
               end
            end
         end
         XFER: begin
            if (mem_ack) begin
`ifdef STAGE_MEMORY_TIMEOUT_EN
               wait_d = '0;
`endif
               if (is_load_q) begin
                  buf_d[lane_q*registerSize +: registerSize] = mem_rdata;
               end
               if (lane_q == LAST_LANE) begin
                  // Final lane bypasses the buffer so the result is ready on this edge
                  vect_out_d = buf_d;
                  vect_out_d[LAST_LANE*registerSize +: registerSize] =
                     is_load_q ? mem_rdata : store_q[LAST_LANE*registerSize +: registerSize];
                  valid_d = 1'b1;
                  lane_d  = '0;
                  state_d = IDLE;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end
`ifdef STAGE_MEMORY_TIMEOUT_EN
            else if (wait_q == TMO_W'(timeoutCycles - 1)) begin
               vect_out_d = '0;
               valid_d    = 1'b1;
               err_d      = 1'b1;
               lane_d     = '0;
               wait_d     = '0;
               state_d    = IDLE;
            end else begin
               wait_d = wait_q + TMO_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef STAGE_MEMORY_TIMEOUT_EN
   assign mem_error = err_q;
`else
   assign mem_error = 1'b0;
`endif

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Pipeline stage directly downstream of the vector execute stage.
- Takes the per-lane result vector plus a memory opcode and base address, and either passes the vector through or runs a lane-serial vector load/store over a single-lane data-memory bus.
- Uses a req/ack handshake on the memory bus and stalls upstream while a transfer is in flight.
- Its registered output vector feeds writeback.

Parameters:
- registerSize, 8, bits per lane.
- vectorSize, 4, lanes per vector (>=1).
- addrSize, 16, memory address width.
- timeoutCycles, 15, max wait per lane for mem_ack (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  upstream presents a valid instruction.
- memOp  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- address  in  addrSize  base address of the vector.
- vect_in  in  vectorSize*registerSize  execute result / store data, lane i = bits [i*registerSize +: registerSize].
- stall  out  1  input not consumed this cycle; upstream holds all inputs.
- vect_out  out  vectorSize*registerSize  registered result to writeback.
- valid_out  out  1  vect_out valid, one-cycle pulse per instruction.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req=1.
- mem_addr  out  addrSize  lane address.
- mem_wdata  out  registerSize  store data for the current lane.
- mem_rdata  in  registerSize  read data, valid when mem_ack=1.
- mem_ack  in  1  request completed this cycle.
- mem_error  out  1  sticky timeout flag (optional feature; otherwise tied 0).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, lane counter=0, vect_out=0, valid_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, load buffer=0, mem_error=0.
  - Reset mid-transfer aborts immediately: mem_req drops without waiting for the clock, and no partial result is emitted.
- States: IDLE, XFER.
- stall = (state==XFER), driven directly from the state register. An input is consumed when valid_in & ~stall.
- IDLE, valid_in=0: valid_out=0 next cycle.
- IDLE, valid_in=1, memOp in {00, 11}: next edge vect_out<=vect_in, valid_out<=1, state stays IDLE. Latency 1 cycle, back-to-back throughput of 1 per cycle.
- IDLE, valid_in=1, memOp in {01, 10}: next edge latch address, vect_in and op; lane=0; state<=XFER; valid_out<=0.
- XFER outputs:
  - mem_req=1.
  - mem_we=(op==store).
  - mem_addr=base+lane, computed modulo 2^addrSize so addresses wrap past the top.
  - mem_wdata=latched lane[lane].
- XFER handshake:
  - mem_ack=0: hold all outputs and lane.
  - mem_ack=1 on a load: buffer[lane]<=mem_rdata.
  - mem_ack=1 and lane<vectorSize-1: lane<=lane+1.
  - mem_ack=1 and lane==vectorSize-1: state<=IDLE; vect_out<=buffer with the final lane taken from mem_rdata (load) or the latched store vector (store); valid_out<=1.
- Memory op latency with zero-wait ack: vectorSize+1 cycles from accept to valid_out.
- A held upstream instruction is accepted in the first IDLE cycle after the transfer, giving a one-cycle bubble.
- mem_ack while not in XFER is ignored.
- mem_rdata is sampled only when mem_ack=1.
- vectorSize=1: XFER lasts until the first ack.
- vect_out holds its value between pulses; only valid_out drops.

Optional Feature:
- Macro: STAGE_MEMORY_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering XFER and on each ack, and increments each XFER cycle with mem_ack=0.
  - When it reaches timeoutCycles, the block aborts the transfer: state<=IDLE, mem_req drops, vect_out<=0, valid_out<=1 pulse, mem_error<=1.
  - mem_error is sticky until reset.
- Undefined: no counter; the block waits indefinitely for mem_ack; mem_error is constant 0.

Test Plan:
- Reset then passthrough: valid_in=1, memOp=00, vect_in={04,03,02,01} -> next cycle vect_out={04,03,02,01}, valid_out=1, stall=0; memOp=11 behaves identically.
- Store, zero-wait ack: address=0x0010, vect_in={DD,CC,BB,AA} -> 4 consecutive cycles with mem_req=1, mem_we=1, addr 0x10..0x13, wdata AA,BB,CC,DD; stall=1 during XFER; valid_out pulse on the cycle after the 4th ack.
- Load with wait states: ack after 2 idle cycles on each lane, rdata 11,22,33,44 -> mem_addr held steady while waiting; vect_out={44,33,22,11}, valid_out=1 exactly once; a held passthrough instruction is accepted the following cycle.
- Address wrap: load at address=0xFFFE -> lane addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-transfer: assert reset after the 2nd lane ack -> mem_req=0 and stall=0 immediately, no valid_out pulse; after release, passthrough works normally.
- With STAGE_MEMORY_TIMEOUT_EN and timeoutCycles=15: never ack -> after 15 waiting cycles, mem_req=0, valid_out=1 with vect_out=0, mem_error=1 and stays 1 through later transfers until reset.
